// File: rtl/an_sec_seq_decoder.sv
// Sequential single-error-correcting AN-code decoder: one shared restoring divider finds
// the syndrome R = W mod A, then the quotient of the corrected word.
// Optional macro AN_SEC_FASTPATH_EN: a zero syndrome skips the second division.
`timescale 1ns/1ps

module an_sec_seq_decoder #(
  parameter int unsigned A       = 18613,
  parameter int          W_WIDTH = 45,
  parameter int          N_WIDTH = 30,
  parameter int          R_WIDTH = 15
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [W_WIDTH-1:0] in_w,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [N_WIDTH-1:0] out_n,
  output logic               out_corrected,
  output logic               out_uncorrectable
);

  // One spare dividend bit so that W + 2^i never overflows.
  localparam int DW = W_WIDTH + 1;
  localparam int CW = $clog2(DW);
  localparam int IW = $clog2(W_WIDTH);
  localparam logic [CW-1:0]      LAST_STEP = CW'(DW - 1);
  localparam logic [R_WIDTH-1:0] A_R       = R_WIDTH'(A);

  typedef logic [W_WIDTH-1:0][R_WIDTH-1:0] syn_t;

  // Residues of +2^i (neg = 0) or -2^i (neg = 1), built from A at elaboration.
  function automatic syn_t build_syn(input bit neg);
    syn_t        t;
    int unsigned p;
    t = '0;
    p = 1 % A;
    for (int i = 0; i < W_WIDTH; i++) begin
      t[i] = R_WIDTH'(neg ? A - p : p);
      p    = (p * 2) % A;
    end
    return t;
  endfunction

  localparam syn_t SYN_POS = build_syn(1'b0);
  localparam syn_t SYN_NEG = build_syn(1'b1);

  typedef enum logic [2:0] {IDLE, DIV1, LOOKUP, DIV2, DONE} state_t;

  state_t             state, state_nx;
  logic [CW-1:0]      cnt;
  logic [R_WIDTH-1:0] rem;
  logic [DW-1:0]      dq;      // dividend shifts out the top, quotient bits shift in the bottom
  logic [DW-1:0]      w_reg;
  logic               corr_reg, unc_reg;

  // Divider step
  logic [R_WIDTH:0]   rem_sh;
  logic               step_ge;
  logic [R_WIDTH-1:0] rem_sub, rem_nx;
  logic [DW-1:0]      dq_nx;

  assign rem_sh  = {rem, dq[DW-1]};
  assign step_ge = rem_sh >= {1'b0, A_R};
  // The true difference is below A, so the modulo-2^R_WIDTH subtraction is exact.
  assign rem_sub = rem_sh[R_WIDTH-1:0] - A_R;
  assign rem_nx  = step_ge ? rem_sub : rem_sh[R_WIDTH-1:0];
  assign dq_nx   = {dq[DW-2:0], step_ge};

  // Syndrome lookup; table entries are distinct and non-zero, so at most one hits.
  logic          hit_pos, hit_neg, is_zero, uncorr;
  logic [IW-1:0] hit_idx;
  logic [DW-1:0] delta_mag, wc;

  // NOTE: every variable written in always_comb gets a default first, otherwise a latch is inferred.
  always_comb begin
    hit_pos = 1'b0;
    hit_neg = 1'b0;
    hit_idx = '0;
    for (int i = 0; i < W_WIDTH; i++) begin
      if (rem == SYN_POS[i]) begin
        hit_pos = 1'b1;
        hit_idx = IW'(i);
      end
      if (rem == SYN_NEG[i]) begin
        hit_neg = 1'b1;
        hit_idx = IW'(i);
      end
    end
  end

  assign is_zero   = (rem == '0);
  assign uncorr    = !is_zero && !hit_pos && !hit_neg;
  assign delta_mag = DW'(1) << hit_idx;
  assign wc        = hit_pos ? w_reg - delta_mag :
                     hit_neg ? w_reg + delta_mag : w_reg;

  assign in_ready = (state == IDLE);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:   if (in_valid) state_nx = DIV1;
      DIV1:   if (cnt == LAST_STEP) state_nx = LOOKUP;
`ifdef AN_SEC_FASTPATH_EN
      LOOKUP: state_nx = is_zero ? DONE : DIV2;
`else
      LOOKUP: state_nx = DIV2;
`endif
      DIV2:   if (cnt == LAST_STEP) state_nx = DONE;
      DONE:   if (out_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt               <= '0;
      rem               <= '0;
      dq                <= '0;
      w_reg             <= '0;
      corr_reg          <= 1'b0;
      unc_reg           <= 1'b0;
      out_valid         <= 1'b0;
      out_n             <= '0;
      out_corrected     <= 1'b0;
      out_uncorrectable <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            w_reg <= {1'b0, in_w};
            dq    <= {1'b0, in_w};
            rem   <= '0;
            cnt   <= '0;
          end
        end
        DIV1: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt + 1'b1;
        end
        LOOKUP: begin
          corr_reg <= hit_pos | hit_neg;
          unc_reg  <= uncorr;
          dq       <= wc;
          rem      <= '0;
          cnt      <= '0;
`ifdef AN_SEC_FASTPATH_EN
          if (is_zero) begin
            out_n             <= dq[N_WIDTH-1:0];
            out_corrected     <= 1'b0;
            out_uncorrectable <= 1'b0;
            out_valid         <= 1'b1;
          end
`endif
        end
        DIV2: begin
          rem <= rem_nx;
          dq  <= dq_nx;
          cnt <= cnt + 1'b1;
          if (cnt == LAST_STEP) begin
            out_n             <= dq_nx[N_WIDTH-1:0];
            out_corrected     <= corr_reg;
            out_uncorrectable <= unc_reg;
            out_valid         <= 1'b1;
          end
        end
        DONE: begin
          if (out_ready) out_valid <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule
